audio_peak_envelope: RTL and testbench

AUDIO_PEAK_ENVELOPE -- requirements
Module: audio_peak_envelope

---
 rtl/audio_peak_envelope.sv | 62 ++++++
 tb/tb_audio_peak_envelope.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/audio_peak_envelope.sv
// audio_peak_envelope: stereo peak envelope follower with frame-synchronous latched outputs
module audio_peak_envelope #(
  parameter int DECAY_SHIFT = 6,
  parameter int DECAY_DIV = 48
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [15:0] iL,
  input  logic [15:0] iR,
  input  logic        iValid,
  input  logic        iSync,
  output logic [14:0] oL,
  output logic [14:0] oR,
  output logic        oUpd
);
  logic [9:0] cnt;
  logic [14:0] envL, envR, envNextL, envNextR;
  logic syncD, decayTick, frameEdge;

  function automatic logic [14:0] magnitude(input logic [15:0] x);
    logic [15:0] n;
    n = ~x + 16'd1;
    return x[15] ? ((x == 16'h8000) ? 15'h7fff : n[14:0]) : x[14:0];
  endfunction

  function automatic logic [14:0] follow(input logic [14:0] env, input logic [14:0] mag,
                                         input logic valid, input logic tick);
    logic [14:0] step;
    step = env >> DECAY_SHIFT;
    step = (step == 15'd0) ? 15'd1 : step;
    return !valid ? env : (mag > env) ? mag : (tick && env != 15'd0) ? env - step : env;
  endfunction

  always_comb begin
    decayTick = iValid && (cnt == 10'(DECAY_DIV - 1));
    frameEdge = syncD && !iSync;
    envNextL = follow(envL, magnitude(iL), iValid, decayTick);
    envNextR = follow(envR, magnitude(iR), iValid, decayTick);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt <= '0;
      envL <= '0;
      envR <= '0;
      oL <= '0;
      oR <= '0;
      oUpd <= 1'b0;
      syncD <= 1'b0;
    end else begin
      syncD <= iSync;
      if (iValid) cnt <= decayTick ? 10'd0 : cnt + 10'd1;
      envL <= envNextL;
      envR <= envNextR;
      if (frameEdge) begin
        oL <= envNextL;
        oR <= envNextR;
      end
      oUpd <= frameEdge;
    end
  end
endmodule

// File: tb/tb_audio_peak_envelope.sv
// tb_audio_peak_envelope: directed checks of attack, saturation, decay, frame latching and reset
module tb_audio_peak_envelope;
  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  logic [15:0] iL = '0, iR = '0;
  logic iValid = 1'b0, iSync = 1'b0;
  logic [14:0] oL, oR, oLB, oRB;
  logic oUpd, oUpdB;
  int errCnt = 0, chkCnt = 0;

  always #5 iCLK = ~iCLK;

  audio_peak_envelope dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iL(iL), .iR(iR), .iValid(iValid), .iSync(iSync),
    .oL(oL), .oR(oR), .oUpd(oUpd)
  );

  audio_peak_envelope #(.DECAY_SHIFT(6), .DECAY_DIV(1)) dutB (
    .iCLK(iCLK), .iRST_N(iRST_N), .iL(iL), .iR(iR), .iValid(iValid), .iSync(iSync),
    .oL(oLB), .oR(oRB), .oUpd(oUpdB)
  );

  task automatic checkVal(input string tag, input int got, input int exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
  endtask

  task automatic sample(input logic [15:0] l, input logic [15:0] r);
    iL = l;
    iR = r;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) sample(16'd0, 16'd0);
  endtask

  task automatic frame();
    iSync = 1'b1;
    tick();
    iSync = 1'b0;
    tick();
  endtask

  task automatic doReset();
    iRST_N = 1'b0;
    tick();
    iRST_N = 1'b1;
  endtask

  initial begin
    tick();
    doReset();
    checkVal("rst_oL", oL, 0);
    checkVal("rst_oR", oR, 0);
    checkVal("rst_oUpd", oUpd, 0);
    tick();
    tick();
    checkVal("no_edge_after_rst", oUpd, 0);

    sample(16'd1000, -16'sd2000);
    frame();
    checkVal("attack_oL", oL, 1000);
    checkVal("attack_oR", oR, 2000);
    checkVal("attack_upd", oUpd, 1);
    tick();
    checkVal("upd_single", oUpd, 0);
    checkVal("hold_oL", oL, 1000);

    doReset();
    sample(16'h8000, 16'h7fff);
    frame();
    checkVal("sat_oL", oL, 32767);
    checkVal("sat_oR", oR, 32767);

    doReset();
    sample(16'hffff, 16'd5);
    frame();
    checkVal("mag_m1", oL, 1);
    checkVal("mag_p5", oR, 5);

    doReset();
    sample(16'd6400, 16'd0);
    zeros(46);
    frame();
    checkVal("predecay_oL", oL, 6400);
    zeros(2);
    frame();
    checkVal("decay_6400", oL, 6300);
    checkVal("decay_zero", oR, 0);
    frame();
    checkVal("upd_unchanged", oUpd, 1);

    doReset();
    sample(16'd40, 16'd0);
    zeros(48);
    frame();
    checkVal("decay_40", oL, 39);

    doReset();
    sample(16'd64, 16'd0);
    sample(16'd0, 16'd0);
    frame();
    checkVal("div1_63", oLB, 63);
    sample(16'd0, 16'd0);
    frame();
    checkVal("div1_62", oLB, 62);

    doReset();
    sample(16'd100, 16'd0);
    frame();
    checkVal("simul_pre", oL, 100);
    iSync = 1'b1;
    tick();
    iSync = 1'b0;
    iL = 16'd500;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    checkVal("simul_oL", oL, 500);
    checkVal("simul_upd", oUpd, 1);
    sample(16'd700, 16'd0);
    tick();
    checkVal("valid_no_edge", oL, 500);
    frame();
    checkVal("later_edge", oL, 700);

    doReset();
    sample(16'd9000, 16'd0);
    doReset();
    checkVal("midrst_oL", oL, 0);
    sample(16'd10, 16'd0);
    frame();
    checkVal("midrst_10", oL, 10);
    zeros(46);
    frame();
    checkVal("cnt_restart_hold", oL, 10);
    zeros(1);
    frame();
    checkVal("cnt_restart_decay", oL, 9);

    iSync = 1'b1;
    tick();
    iRST_N = 1'b0;
    iSync = 1'b0;
    iL = 16'd5;
    iValid = 1'b1;
    tick();
    iRST_N = 1'b1;
    iValid = 1'b0;
    checkVal("rst_dom_oL", oL, 0);
    checkVal("rst_dom_upd", oUpd, 0);
    frame();
    checkVal("rst_dom_env", oL, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
